// File: rtl/plane_controller.sv
// Aeroplane sprite stage: draws the 8x8 plane, latches wall hits and runs the
// play/crash/respawn/game-over sequence once per frame. Optional: PLANE_GRACE_EN.
module plane_controller #(
    parameter logic [8:0] START_X      = 9'd16,
    parameter logic [8:0] START_Y      = 9'd120,
    parameter logic [8:0] X_MIN        = 9'd8,
    parameter logic [8:0] X_MAX        = 9'd240,
    parameter logic [8:0] Y_MIN        = 9'd24,
    parameter logic [8:0] Y_MAX        = 9'd224,
    parameter int         SPEED        = 2,
    parameter logic [8:0] FRAME_LINE   = 9'd240,
    parameter logic [5:0] CRASH_FRAMES = 6'd48,
    parameter logic [1:0] LIVES_INIT   = 2'd3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic       playfield_gfx,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_start,
    output logic       plane_gfx,
    output logic       crash,
    output logic       game_over,
    output logic [1:0] lives,
    output logic [8:0] plane_x,
    output logic [8:0] plane_y
);
    typedef enum logic [1:0] {S_PLAY, S_CRASH, S_OVER} state_t;

    localparam logic [8:0] STEP = 9'(SPEED);

    state_t     state_q, state_d;
    logic [8:0] x_q, x_d, y_q, y_d;
    logic [1:0] lives_q, lives_d;
    logic [5:0] crash_cnt_q, crash_cnt_d;
    logic       hit_q, hit_d;
    logic       gfx_q, gfx_d;

    logic [8:0] dx, dy;
    logic [8:0] x_move, y_move;
    logic [7:0] rom_row;
    logic       in_box, rom_bit, visible, play_visible, sprite_bit, tick;
    logic       grace_active;

`ifdef PLANE_GRACE_EN
    localparam logic [5:0] GRACE_FRAMES = 6'd60;
    logic [5:0] grace_q, grace_d;
    logic       respawn;

    assign grace_active = (grace_q != 6'd0);
    assign play_visible = grace_active ? grace_q[2] : 1'b1;
    assign respawn = tick && (((state_q == S_CRASH) && (crash_cnt_q <= 6'd1) && (lives_q != 2'd0))
                           || ((state_q == S_OVER) && btn_start));

    always_comb begin
        grace_d = grace_q;
        if (respawn)
            grace_d = GRACE_FRAMES;
        else if (tick && (state_q == S_PLAY) && grace_active)
            grace_d = grace_q - 6'd1;
    end
`else
    assign grace_active = 1'b0;
    assign play_visible = 1'b1;
`endif

    // Unsigned wrap makes positions left of / above the sprite look huge.
    assign dx     = hpos - x_q;
    assign dy     = vpos - y_q;
    assign in_box = (dx < 9'd8) && (dy < 9'd8);
    assign tick   = (vpos == FRAME_LINE) && (hpos == 9'd0);

    always_comb begin
        case (dy[2:0])
            3'd0:    rom_row = 8'b0001_0000;
            3'd1:    rom_row = 8'b0001_1000;
            3'd2:    rom_row = 8'b1001_1100;
            3'd3:    rom_row = 8'b1111_1111;
            3'd4:    rom_row = 8'b1111_1111;
            3'd5:    rom_row = 8'b1001_1100;
            3'd6:    rom_row = 8'b0001_1000;
            default: rom_row = 8'b0001_0000;
        endcase
    end

    assign rom_bit = rom_row[3'd7 - dx[2:0]];

    always_comb begin
        case (state_q)
            S_CRASH: visible = crash_cnt_q[2];
            S_PLAY:  visible = play_visible;
            default: visible = 1'b1;
        endcase
    end

    assign sprite_bit = in_box && rom_bit && visible;

    // Opposing buttons cancel; moves past a bound land exactly on it.
    always_comb begin
        x_move = x_q;
        y_move = y_q;
        if (btn_right && !btn_left)
            x_move = (x_q > X_MAX - STEP) ? X_MAX : x_q + STEP;
        else if (btn_left && !btn_right)
            x_move = (x_q < X_MIN + STEP) ? X_MIN : x_q - STEP;
        if (btn_down && !btn_up)
            y_move = (y_q > Y_MAX - STEP) ? Y_MAX : y_q + STEP;
        else if (btn_up && !btn_down)
            y_move = (y_q < Y_MIN + STEP) ? Y_MIN : y_q - STEP;
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        lives_d     = lives_q;
        crash_cnt_d = crash_cnt_q;
        gfx_d       = sprite_bit;
        hit_d       = hit_q || (sprite_bit && playfield_gfx && (state_q == S_PLAY) && !grace_active);
        if (tick) begin
            hit_d = 1'b0;
            case (state_q)
                S_PLAY: begin
                    if (hit_q) begin
                        lives_d     = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                        crash_cnt_d = CRASH_FRAMES;
                        state_d     = S_CRASH;
                    end else begin
                        x_d = x_move;
                        y_d = y_move;
                    end
                end
                S_CRASH: begin
                    crash_cnt_d = crash_cnt_q - 6'd1;
                    if (crash_cnt_q <= 6'd1) begin
                        crash_cnt_d = 6'd0;
                        if (lives_q == 2'd0) begin
                            state_d = S_OVER;
                        end else begin
                            x_d     = START_X;
                            y_d     = START_Y;
                            state_d = S_PLAY;
                        end
                    end
                end
                default: begin
                    if (btn_start) begin
                        lives_d = LIVES_INIT;
                        x_d     = START_X;
                        y_d     = START_Y;
                        state_d = S_PLAY;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_PLAY;
            x_q         <= START_X;
            y_q         <= START_Y;
            lives_q     <= LIVES_INIT;
            crash_cnt_q <= 6'd0;
            hit_q       <= 1'b0;
            gfx_q       <= 1'b0;
`ifdef PLANE_GRACE_EN
            grace_q     <= 6'd0;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            lives_q     <= lives_d;
            crash_cnt_q <= crash_cnt_d;
            hit_q       <= hit_d;
            gfx_q       <= gfx_d;
`ifdef PLANE_GRACE_EN
            grace_q     <= grace_d;
`endif
        end
    end

    assign plane_gfx = gfx_q;
    assign crash     = (state_q == S_CRASH);
    assign game_over = (state_q == S_OVER);
    assign lives     = lives_q;
    assign plane_x   = x_q;
    assign plane_y   = y_q;

endmodule

// File: tb/tb_plane_controller.sv
// Self-checking bench for plane_controller: sprite ROM table, movement clamping,
// crash/respawn, game over and restart, with optional PLANE_GRACE_EN checks.
module tb_plane_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] hpos, vpos;
    logic       playfield_gfx;
    logic       btn_up, btn_down, btn_left, btn_right, btn_start;
    logic       plane_gfx, crash, game_over;
    logic [1:0] lives;
    logic [8:0] plane_x, plane_y;

    int n_checks = 0;
    int n_fail   = 0;
    int ex, ey;

    localparam logic [4:0] B_NONE  = 5'b00000;
    localparam logic [4:0] B_RIGHT = 5'b00001;
    localparam logic [4:0] B_LEFT  = 5'b00010;
    localparam logic [4:0] B_DOWN  = 5'b00100;
    localparam logic [4:0] B_UP    = 5'b01000;
    localparam logic [4:0] B_START = 5'b10000;

    typedef struct {
        logic [8:0] h;
        logic [8:0] v;
        logic       pf;
        logic       exp_gfx;
    } vec_t;

    vec_t vecs [17];

    plane_controller dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
        .playfield_gfx(playfield_gfx),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_start(btn_start),
        .plane_gfx(plane_gfx), .crash(crash), .game_over(game_over),
        .lives(lives), .plane_x(plane_x), .plane_y(plane_y)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [8:0] h, input logic [8:0] v,
                                 input logic pf, input logic [4:0] b);
        hpos = h;
        vpos = v;
        playfield_gfx = pf;
        {btn_start, btn_up, btn_down, btn_left, btn_right} = b;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkState(input string name, input int x, input int y,
                              input int l, input int c, input int o);
        checkOutput({name, " plane_x"}, int'(plane_x), x);
        checkOutput({name, " plane_y"}, int'(plane_y), y);
        checkOutput({name, " lives"}, int'(lives), l);
        checkOutput({name, " crash"}, int'(crash), c);
        checkOutput({name, " game_over"}, int'(game_over), o);
    endtask

    task automatic frameTick(input logic [4:0] b);
        applyStimulus(9'd0, 9'd240, 1'b0, b);
    endtask

    // Wall pixel under row 0, column 3 (opaque), then the frame tick.
    task automatic crashAttempt(input logic [4:0] tick_buttons);
        applyStimulus(9'(ex + 3), 9'(ey), 1'b1, B_NONE);
        frameTick(tick_buttons);
    endtask

    task automatic waitGrace();
`ifdef PLANE_GRACE_EN
        repeat (60) frameTick(B_NONE);
`endif
    endtask

    initial begin
        vecs[0]  = '{9'd15, 9'd120, 1'b0, 1'b0};
        vecs[1]  = '{9'd16, 9'd120, 1'b0, 1'b0};
        vecs[2]  = '{9'd19, 9'd120, 1'b0, 1'b1};
        vecs[3]  = '{9'd20, 9'd120, 1'b0, 1'b0};
        vecs[4]  = '{9'd23, 9'd123, 1'b0, 1'b1};
        vecs[5]  = '{9'd24, 9'd123, 1'b0, 1'b0};
        vecs[6]  = '{9'd16, 9'd123, 1'b0, 1'b1};
        vecs[7]  = '{9'd15, 9'd123, 1'b0, 1'b0};
        vecs[8]  = '{9'd18, 9'd122, 1'b0, 1'b0};
        vecs[9]  = '{9'd16, 9'd122, 1'b0, 1'b1};
        vecs[10] = '{9'd21, 9'd122, 1'b0, 1'b1};
        vecs[11] = '{9'd22, 9'd122, 1'b0, 1'b0};
        vecs[12] = '{9'd19, 9'd127, 1'b0, 1'b1};
        vecs[13] = '{9'd19, 9'd128, 1'b0, 1'b0};
        vecs[14] = '{9'd19, 9'd119, 1'b0, 1'b0};
        vecs[15] = '{9'd16, 9'd120, 1'b1, 1'b0};
        vecs[16] = '{9'd22, 9'd122, 1'b1, 1'b0};

        reset = 1'b1;
        hpos = 9'd0; vpos = 9'd300; playfield_gfx = 1'b0;
        {btn_start, btn_up, btn_down, btn_left, btn_right} = B_NONE;
        @(posedge clk); @(posedge clk); #1;
        checkState("reset", 16, 120, 3, 0, 0);
        checkOutput("reset plane_gfx", int'(plane_gfx), 0);
        reset = 1'b0;
        ex = 16; ey = 120;

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].h, vecs[i].v, vecs[i].pf, B_NONE);
            checkOutput($sformatf("rom vec%0d plane_gfx", i), int'(plane_gfx), int'(vecs[i].exp_gfx));
        end
        frameTick(B_NONE);
        checkState("idle frame", 16, 120, 3, 0, 0);

        for (int i = 0; i < 200; i++) begin
            frameTick(B_RIGHT);
            ex = (ex + 2 > 240) ? 240 : ex + 2;
            checkOutput($sformatf("right frame%0d plane_x", i), int'(plane_x), ex);
        end
        checkOutput("right clamp", int'(plane_x), 240);
        repeat (5) frameTick(B_LEFT | B_RIGHT);
        checkOutput("left+right plane_x", int'(plane_x), 240);
        frameTick(B_LEFT);
        checkOutput("left step plane_x", int'(plane_x), 238);
        repeat (60) frameTick(B_UP);
        checkOutput("up clamp plane_y", int'(plane_y), 24);
        repeat (5) frameTick(B_UP | B_DOWN);
        checkOutput("up+down plane_y", int'(plane_y), 24);
        frameTick(B_DOWN);
        checkOutput("down step plane_y", int'(plane_y), 26);

        #2 reset = 1'b1;
        #1 checkState("mid-frame reset", 16, 120, 3, 0, 0);
        @(posedge clk); #1 reset = 1'b0;
        ex = 16; ey = 120;

        repeat (3) frameTick(B_RIGHT);
        ex = 22;
        checkState("pre-crash", 22, 120, 3, 0, 0);
        crashAttempt(B_NONE);
        checkState("crash 1", 22, 120, 2, 1, 0);
        repeat (47) frameTick(B_RIGHT);
        checkState("crash 1 held", 22, 120, 2, 1, 0);
        frameTick(B_NONE);
        checkState("respawn 1", 16, 120, 2, 0, 0);
        ex = 16; ey = 120;

`ifdef PLANE_GRACE_EN
        crashAttempt(B_NONE);
        checkState("grace first frame", 16, 120, 2, 0, 0);
        repeat (59) frameTick(B_NONE);
        crashAttempt(B_NONE);
        checkState("crash 2 after grace", 16, 120, 1, 1, 0);
`else
        crashAttempt(B_NONE);
        checkState("crash 2 first frame", 16, 120, 1, 1, 0);
`endif
        repeat (48) frameTick(B_NONE);
        checkState("respawn 2", 16, 120, 1, 0, 0);
        waitGrace();
        frameTick(B_RIGHT);
        ex = 18;
        crashAttempt(B_NONE);
        checkState("crash 3", 18, 120, 0, 1, 0);
        repeat (47) frameTick(B_NONE);
        checkState("crash 3 held", 18, 120, 0, 1, 0);
        frameTick(B_NONE);
        checkState("game over", 18, 120, 0, 0, 1);
        frameTick(B_RIGHT);
        checkState("over frozen", 18, 120, 0, 0, 1);
        crashAttempt(B_NONE);
        checkState("over no hit", 18, 120, 0, 0, 1);
        frameTick(B_START);
        checkState("restart", 16, 120, 3, 0, 0);
        ex = 16; ey = 120;

        waitGrace();
        crashAttempt(B_START);
        checkState("hit beats start", 16, 120, 2, 1, 0);
        repeat (10) frameTick(B_NONE);
        #2 reset = 1'b1;
        #1 checkState("mid-crash reset", 16, 120, 3, 0, 0);
        @(posedge clk); #1 reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/plane_controller.md
Name: plane_controller

Overview:
- Per-pixel stage directly downstream of the maze playfield generator.
- Consumes the beam position and the playfield_gfx bit that the generator produces for that position.
- Renders the 8x8 aeroplane sprite and detects sprite/wall overlap during the frame.
- Runs the play/crash/respawn/game-over state machine once per frame. The video mixer ORs plane_gfx with playfield_gfx.

Parameters:
- START_X, 9'd16, plane left-edge column after reset or respawn.
- START_Y, 9'd120, plane top-edge line after reset or respawn.
- X_MIN, 9'd8, lowest allowed left edge.
- X_MAX, 9'd240, highest allowed left edge.
- Y_MIN, 9'd24, lowest allowed top edge.
- Y_MAX, 9'd224, highest allowed top edge.
- SPEED, 2, pixels moved per frame per axis.
- FRAME_LINE, 9'd240, vpos at which the frame tick fires (first non-playfield line).
- CRASH_FRAMES, 6'd48, frames spent in CRASH.
- LIVES_INIT, 2'd3, lives at start.

Ports:
- clk, input, 1, pixel clock; one hpos step per clk.
- reset, input, 1, asynchronous, active-high.
- hpos, input, 9, beam column.
- vpos, input, 9, beam line.
- playfield_gfx, input, 1, wall bit for the current hpos/vpos (same cycle).
- btn_up, btn_down, btn_left, btn_right, input, 1 each, level-sensitive controls.
- btn_start, input, 1, restart from OVER.
- plane_gfx, output, 1, sprite pixel, registered.
- crash, output, 1, high while in CRASH.
- game_over, output, 1, high while in OVER.
- lives, output, 2, remaining lives.
- plane_x, output, 9, current left edge.
- plane_y, output, 9, current top edge.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-high. While reset is high:
  - plane_x=START_X, plane_y=START_Y.
  - lives=LIVES_INIT, crash=0, game_over=0, plane_gfx=0.
  - State PLAY, hit latch 0, crash counter 0.
- Sprite box: in_box = (hpos-plane_x)<8 and (vpos-plane_y)<8, unsigned 9-bit subtraction, so wrap-around correctly excludes positions left of or above the sprite.
- Sprite bitmap: fixed 8x8 aeroplane ROM; row = (vpos-plane_y)[2:0], column = (hpos-plane_x)[2:0].
- sprite_bit = in_box and ROM bit and visible.
  - visible=1 in PLAY and OVER.
  - visible=crash_cnt[2] in CRASH (blink).
- plane_gfx is sprite_bit registered: 1-cycle latency relative to hpos.
- Hit latch: set in any cycle where sprite_bit and playfield_gfx are both 1, same cycle, unregistered compare. Sticky until the frame tick. Set only in PLAY.
- Frame tick: one-cycle pulse when vpos==FRAME_LINE and hpos==0. All position/state updates occur only on the tick, never mid-frame.
- PLAY on tick:
  - Hit latch=1: lives <= lives-1, crash_cnt <= CRASH_FRAMES, go to CRASH. Position unchanged.
  - Hit latch=0: move by SPEED per axis.
    - Left/right pressed together: no X move. Up/down pressed together: no Y move.
    - Results clamp to [X_MIN,X_MAX] and [Y_MIN,Y_MAX]; a move past a bound lands exactly on the bound.
  - Hit latch clears on every tick.
- CRASH:
  - Buttons are ignored; hits are not latched.
  - On each tick crash_cnt decrements.
  - On the tick where crash_cnt==1:
    - lives==0 → OVER.
    - Otherwise reload START_X/START_Y → PLAY.
- OVER:
  - game_over=1; sprite is frozen at the crash position.
  - btn_start sampled on tick: lives <= LIVES_INIT, position reloads START_X/START_Y, go to PLAY.
- lives saturates at 0 and never underflows. The decrement happens on entry to CRASH, so the last crash shows lives=0 during CRASH.
- Simultaneous hit and btn_start in PLAY: btn_start is ignored.
- Reset asserted mid-frame or mid-CRASH: immediate return to the reset values above.

Optional Feature:
- Macro PLANE_GRACE_EN.
- Defined:
  - After every respawn and every restart from OVER, a 6-bit grace counter loads 6'd60.
  - It decrements on each tick while in PLAY.
  - While it is nonzero, the hit latch is held at 0 and visible=grace_cnt[2].
- Undefined:
  - No grace counter; collisions are detected from the first frame after respawn.
  - Sprite is always visible in PLAY.

Test Plan:
- Reset, then run 1 frame with no buttons → plane_x=16, plane_y=120, lives=3, crash=0, game_over=0. plane_gfx matches the ROM at hpos 16..23 / vpos 120..127, one cycle late.
- Hold btn_right for 200 frames with a clear playfield → plane_x steps 16,18,20,... and stops at exactly 240. Left+right together for 5 frames → plane_x unchanged.
- Force playfield_gfx=1 for a single pixel inside the sprite's opaque region → at the next tick crash=1 and lives=2. After 48 ticks, plane_x=16, plane_y=120, crash=0.
- Playfield wall pixel under a transparent sprite bit → no crash, lives stays 3.
- Three crashes in succession → lives 3→2→1→0, game_over=1 after the third CRASH. btn_start held at a tick → lives=3, game_over=0, position at start.
- With PLANE_GRACE_EN defined: collide on the first frame after respawn → no crash. Collide at frame 61 after respawn → crash. Without the macro: collide on the first frame → crash.
